// File: rtl/fu_result_buffer_pkg.sv
// Purpose: shared widths and packet types for the FU result buffer and its users.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fu_result_buffer_pkg;

  localparam int NUM_FU_P   = 8;
  localparam int WB_WIDTH_P = 3;
  localparam int XLEN_P     = 32;
  localparam int PR_W_P     = 6;
  localparam int ROB_W_P    = 5;

  // One completed result; also the layout of a single fu_c_in lane.
  typedef struct packed {
    logic [PR_W_P-1:0]  dest_pr;
    logic [XLEN_P-1:0]  dest_value;
    logic [ROB_W_P-1:0] rob_entry;
  } FU_COMPLETE_PACKET;

  // One bit per functional unit (finish / ready / stall vectors).
  typedef logic [NUM_FU_P-1:0] FU_STATE_PACKET;

endpackage

// File: rtl/fu_result_buffer_slot.sv
// Purpose: one result slot (valid + payload) with capture, hold, release and squash clear.
// Latency: captured payload is visible on data_o the cycle after capture_i.
// Backpressure: holds contents while valid and not released; the parent derives readiness.
// Ports: clock/reset (async active-low), squash, capture_i, release_i, data_i -> valid_o, data_o.
module fu_result_slot #(
  parameter int W = 43
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         squash,
  input  logic         capture_i,
  input  logic         release_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  // Squash beats capture so a same-cycle accept is discarded; capture beats
  // release so a drained slot can be refilled in the same cycle.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (squash) begin
      valid_d = 1'b0;
    end else if (capture_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (release_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/fu_result_buffer.sv
// Purpose: per-FU result slots feeding the complete stage as up to WB_WIDTH packed lanes.
// Latency: a result accepted at edge N is on fu_finish/fu_c_in in cycle N+1.
// Backpressure: fu_ready[i] drops only while slot i is full and stalled; drain-and-refill same cycle.
// Ports: clock, reset (async active-low), squash, fu_valid/fu_dest_pr/fu_value/fu_rob_entry in,
//        fu_ready out, fu_c_stall in, fu_finish out, fu_c_in out (lane 0 in the low bits).
// Optional: FU_RESULT_PERF_EN adds perf_stall_cycles and perf_max_occupancy outputs.
module fu_result_buffer
  import fu_result_buffer_pkg::*;
#(
  parameter int NUM_FU   = NUM_FU_P,
  parameter int WB_WIDTH = WB_WIDTH_P,
  parameter int XLEN     = XLEN_P,
  parameter int PR_W     = PR_W_P,
  parameter int ROB_W    = ROB_W_P
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   squash,
  input  logic [NUM_FU-1:0]                      fu_valid,
  input  logic [NUM_FU*PR_W-1:0]                 fu_dest_pr,
  input  logic [NUM_FU*XLEN-1:0]                 fu_value,
  input  logic [NUM_FU*ROB_W-1:0]                fu_rob_entry,
  output logic [NUM_FU-1:0]                      fu_ready,
  input  logic [NUM_FU-1:0]                      fu_c_stall,
  output logic [NUM_FU-1:0]                      fu_finish,
  output logic [WB_WIDTH*(PR_W+XLEN+ROB_W)-1:0]  fu_c_in
`ifdef FU_RESULT_PERF_EN
  ,
  output logic [31:0]                            perf_stall_cycles,
  output logic [3:0]                             perf_max_occupancy
`endif
);

  localparam int PKT_W = PR_W + XLEN + ROB_W;

  logic [NUM_FU-1:0] valid_q;
  logic [NUM_FU-1:0] grant;
  logic [NUM_FU-1:0] acc;
  logic [PKT_W-1:0]  slot_dat [NUM_FU];
  logic [PKT_W-1:0]  lane_dat [WB_WIDTH];

  // Stall on an empty slot has no effect because grant/ready are gated by valid_q.
  assign grant    = valid_q & ~fu_c_stall;
  assign fu_ready = ~valid_q | grant;
  assign acc      = fu_valid & fu_ready;

  for (genvar i = 0; i < NUM_FU; i++) begin : g_slot
    fu_result_slot #(.W(PKT_W)) u_slot (
      .clock     (clock),
      .reset     (reset),
      .squash    (squash),
      .capture_i (acc[i]),
      .release_i (grant[i]),
      .data_i    ({fu_dest_pr[i*PR_W +: PR_W],
                   fu_value[i*XLEN +: XLEN],
                   fu_rob_entry[i*ROB_W +: ROB_W]}),
      .valid_o   (valid_q[i]),
      .data_o    (slot_dat[i])
    );
  end

  assign fu_finish = valid_q;

  // Fixed lowest-index-first selection of up to WB_WIDTH full slots; this is
  // the same order the complete stage uses when it builds fu_c_stall.
  always_comb begin
    int n;
    n = 0;
    for (int l = 0; l < WB_WIDTH; l++) lane_dat[l] = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (valid_q[i] && (n < WB_WIDTH)) begin
        lane_dat[n] = slot_dat[i];
        n = n + 1;
      end
    end
  end

  for (genvar l = 0; l < WB_WIDTH; l++) begin : g_lane
    assign fu_c_in[l*PKT_W +: PKT_W] = lane_dat[l];
  end

`ifdef FU_RESULT_PERF_EN
  logic [3:0] occ;

  always_comb begin
    occ = '0;
    for (int i = 0; i < NUM_FU; i++) occ = occ + 4'(valid_q[i]);
  end

  // Counters survive squash; only reset clears them.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_stall_cycles  <= '0;
      perf_max_occupancy <= '0;
    end else begin
      if (|(valid_q & fu_c_stall) && (perf_stall_cycles != 32'hFFFF_FFFF))
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (occ > perf_max_occupancy)
        perf_max_occupancy <= occ;
    end
  end
`endif

`ifndef SYNTHESIS
  // An FU must not present a result to a slot that is full and stalled.
  a_no_overrun: assert property (@(posedge clock) disable iff (!reset)
                                 ((fu_valid & ~fu_ready) == '0))
    else $error("fu_result_buffer: result presented to a slot that is not ready");
`endif

endmodule

// File: tb/tb_fu_result_buffer.sv
// Purpose: self-checking bench for fu_result_buffer (vector table, scoreboard, corner sequences).
// Latency: inputs driven 1ns after the rising edge, outputs sampled on the falling edge.
// Backpressure: fu_c_stall patterns are driven by the tables and sequences below.
module tb_fu_result_buffer;
  import fu_result_buffer_pkg::*;

  localparam int PKT_W = PR_W_P + XLEN_P + ROB_W_P;

  logic                          clock = 1'b0;
  logic                          reset = 1'b0;
  logic                          squash = 1'b0;
  logic [NUM_FU_P-1:0]           fu_valid = '0;
  logic [NUM_FU_P*PR_W_P-1:0]    fu_dest_pr = '0;
  logic [NUM_FU_P*XLEN_P-1:0]    fu_value = '0;
  logic [NUM_FU_P*ROB_W_P-1:0]   fu_rob_entry = '0;
  logic [NUM_FU_P-1:0]           fu_ready;
  logic [NUM_FU_P-1:0]           fu_c_stall = '0;
  logic [NUM_FU_P-1:0]           fu_finish;
  logic [WB_WIDTH_P*PKT_W-1:0]   fu_c_in;
`ifdef FU_RESULT_PERF_EN
  logic [31:0]                   perf_stall_cycles;
  logic [3:0]                    perf_max_occupancy;
`endif

  fu_result_buffer dut (
    .clock        (clock),
    .reset        (reset),
    .squash       (squash),
    .fu_valid     (fu_valid),
    .fu_dest_pr   (fu_dest_pr),
    .fu_value     (fu_value),
    .fu_rob_entry (fu_rob_entry),
    .fu_ready     (fu_ready),
    .fu_c_stall   (fu_c_stall),
    .fu_finish    (fu_finish),
    .fu_c_in      (fu_c_in)
`ifdef FU_RESULT_PERF_EN
    ,
    .perf_stall_cycles  (perf_stall_cycles),
    .perf_max_occupancy (perf_max_occupancy)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Per-row, per-FU payload so every captured result is distinguishable.
  function automatic FU_COMPLETE_PACKET mk(input int row, input int i);
    FU_COMPLETE_PACKET p;
    p.dest_pr    = PR_W_P'(i);
    p.dest_value = 32'hC0DE_0000 | 32'(row << 8) | 32'(i);
    p.rob_entry  = ROB_W_P'(row + i);
    return p;
  endfunction

  function automatic FU_COMPLETE_PACKET exp_lane(input int src, input int slot);
    if (slot < 0) return '0;
    return mk(src, slot);
  endfunction

  function automatic FU_COMPLETE_PACKET lane(input int l);
    return fu_c_in[l*PKT_W +: PKT_W];
  endfunction

  task automatic set_fu(input int i, input FU_COMPLETE_PACKET p);
    fu_dest_pr[i*PR_W_P +: PR_W_P]      = p.dest_pr;
    fu_value[i*XLEN_P +: XLEN_P]        = p.dest_value;
    fu_rob_entry[i*ROB_W_P +: ROB_W_P]  = p.rob_entry;
  endtask

  typedef struct {
    logic [7:0] v;
    logic [7:0] st;
    logic       sq;
    logic [7:0] fin;
    logic [7:0] rdy;
    int         src;
    int         l0;
    int         l1;
    int         l2;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [7:0] v, input logic [7:0] st, input logic sq,
                     input logic [7:0] fin, input logic [7:0] rdy,
                     input int src, input int l0, input int l1, input int l2);
    vec_t e;
    e.v = v; e.st = st; e.sq = sq; e.fin = fin; e.rdy = rdy;
    e.src = src; e.l0 = l0; e.l1 = l1; e.l2 = l2;
    tbl.push_back(e);
  endtask

  FU_COMPLETE_PACKET sb[$];
  FU_COMPLETE_PACKET p;
  int got;

  initial begin
    // Row r: inputs applied during cycle r; outputs checked in that cycle.
    //  valid   stall  sq  finish ready  src lane slots
    add(8'h04, 8'h00, 0, 8'h00, 8'hFF, -1, -1, -1, -1);
    add(8'h00, 8'h00, 0, 8'h04, 8'hFF,  0,  2, -1, -1);
    add(8'h00, 8'h00, 0, 8'h00, 8'hFF, -1, -1, -1, -1);
    add(8'hA7, 8'h00, 0, 8'h00, 8'hFF, -1, -1, -1, -1);
    add(8'h00, 8'hA0, 0, 8'hA7, 8'h5F,  3,  0,  1,  2);
    add(8'h00, 8'h00, 0, 8'hA0, 8'hFF,  3,  5,  7, -1);
    add(8'h00, 8'h00, 0, 8'h00, 8'hFF, -1, -1, -1, -1);
    add(8'h10, 8'h00, 0, 8'h00, 8'hFF, -1, -1, -1, -1);
    add(8'h00, 8'h10, 0, 8'h10, 8'hEF,  7,  4, -1, -1);
    add(8'h00, 8'h10, 0, 8'h10, 8'hEF,  7,  4, -1, -1);
    add(8'h00, 8'h10, 0, 8'h10, 8'hEF,  7,  4, -1, -1);
    add(8'h00, 8'h00, 0, 8'h10, 8'hFF,  7,  4, -1, -1);
    add(8'h00, 8'h00, 0, 8'h00, 8'hFF, -1, -1, -1, -1);
    add(8'h42, 8'h00, 0, 8'h00, 8'hFF, -1, -1, -1, -1);
    add(8'h04, 8'h00, 1, 8'h42, 8'hFF, 13,  1,  6, -1);
    add(8'h00, 8'hFF, 0, 8'h00, 8'hFF, -1, -1, -1, -1);

    // Reset state.
    #12;
    chk("reset_finish", 64'(fu_finish), 64'h0);
    chk("reset_c_in", 64'(fu_c_in[63:0]), 64'h0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("reset_ready", 64'(fu_ready), 64'hFF);

    // Vector table.
    for (int r = 0; r < tbl.size(); r++) begin
      @(posedge clock);
      #1;
      fu_valid   = tbl[r].v;
      fu_c_stall = tbl[r].st;
      squash     = tbl[r].sq;
      for (int i = 0; i < NUM_FU_P; i++) set_fu(i, mk(r, i));
      @(negedge clock);
      chk($sformatf("row%0d_finish", r), 64'(fu_finish), 64'(tbl[r].fin));
      chk($sformatf("row%0d_ready", r), 64'(fu_ready), 64'(tbl[r].rdy));
      chk($sformatf("row%0d_lane0", r), 64'(lane(0)), 64'(exp_lane(tbl[r].src, tbl[r].l0)));
      chk($sformatf("row%0d_lane1", r), 64'(lane(1)), 64'(exp_lane(tbl[r].src, tbl[r].l1)));
      chk($sformatf("row%0d_lane2", r), 64'(lane(2)), 64'(exp_lane(tbl[r].src, tbl[r].l2)));
    end

    // Single result with explicit field values.
    @(posedge clock);
    #1;
    fu_valid = 8'h04; fu_c_stall = '0; squash = 1'b0;
    p.dest_pr = 6'd5; p.dest_value = 32'hDEAD_BEEF; p.rob_entry = 5'd3;
    set_fu(2, p);
    @(posedge clock);
    #1;
    fu_valid = '0;
    @(negedge clock);
    chk("single_finish", 64'(fu_finish), 64'h04);
    chk("single_lane0", 64'(lane(0)), 64'({6'd5, 32'hDEAD_BEEF, 5'd3}));
    chk("single_lane1", 64'(lane(1)), 64'h0);
    chk("single_lane2", 64'(lane(2)), 64'h0);
    @(negedge clock);
    chk("single_drained", 64'(fu_finish), 64'h0);

    // Drain-refill on FU3: one result per cycle, order preserved, none lost.
    got = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clock);
      #1;
      if (k < 10) begin
        fu_valid = 8'h08;
        p.dest_pr = 6'd3; p.dest_value = 32'h1000_0000 + 32'(k); p.rob_entry = 5'(k);
        set_fu(3, p);
        sb.push_back(p);
      end else begin
        fu_valid = '0;
      end
      @(negedge clock);
      if (k < 10) chk($sformatf("drain_ready_k%0d", k), 64'(fu_ready[3]), 64'h1);
      if (fu_finish[3]) begin
        if (sb.size() == 0) begin
          chk("drain_unexpected_result", 64'(lane(0)), 64'h0);
        end else begin
          chk($sformatf("drain_lane0_n%0d", got), 64'(lane(0)), 64'(sb.pop_front()));
          got++;
        end
      end
    end
    chk("drain_count", 64'(got), 64'd10);
    chk("drain_sb_empty", 64'(sb.size()), 64'd0);

    // Asynchronous reset with three full, stalled slots.
    @(posedge clock);
    #1;
    fu_valid = 8'h07;
    for (int i = 0; i < NUM_FU_P; i++) set_fu(i, mk(20, i));
    @(posedge clock);
    #1;
    fu_valid = '0; fu_c_stall = 8'h07;
    #2;
    chk("areset_pre_finish", 64'(fu_finish), 64'h07);
`ifdef FU_RESULT_PERF_EN
    chk("perf_stall_pre", 64'(perf_stall_cycles), 64'd4);
    chk("perf_maxocc_pre", 64'(perf_max_occupancy), 64'd5);
`endif
    reset = 1'b0;
    #1;
    chk("areset_finish", 64'(fu_finish), 64'h0);
    chk("areset_c_in", 64'(fu_c_in[63:0]), 64'h0);
    chk("areset_ready", 64'(fu_ready), 64'hFF);
`ifdef FU_RESULT_PERF_EN
    chk("perf_stall_reset", 64'(perf_stall_cycles), 64'd0);
    chk("perf_maxocc_reset", 64'(perf_max_occupancy), 64'd0);
`endif
    @(negedge clock);
    fu_c_stall = '0;
    reset = 1'b1;
    @(negedge clock);
    chk("post_reset_finish", 64'(fu_finish), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute bound so the run always terminates.
  initial begin
    #20000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
